diffeq_solver_fx: RTL

DIFFEQ_SOLVER_FX -- requirements
Module: diffeq_solver_fx

---
 rtl/diffeq_pkg.sv | 21 ++
 rtl/diffeq_solver_fx_mul.sv | 38 +++
 rtl/diffeq_solver_fx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/diffeq_pkg.sv
// Shared FSM state encoding and saturation bound helpers for the fixed-point ODE solver.
package diffeq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    C3   = 3'd3,
    C4   = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/diffeq_solver_fx_mul.sv
// fx_mul_sat: signed fixed-point multiply, floor shift by FRAC, saturate to WIDTH bits.
// Purely combinational; sat flags that the result was clipped.
module fx_mul_sat
  import diffeq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    sat
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] PMAX = PW'(sat_max(WIDTH));
  localparam logic signed [PW-1:0] PMIN = PW'(sat_min(WIDTH));

  logic signed [PW-1:0] ae, be, prod, shr;

  assign ae   = {{WIDTH{a[WIDTH-1]}}, a};
  assign be   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = ae * be;
  assign shr  = prod >>> FRAC;

  always_comb begin
    sat = 1'b0;
    p   = shr[WIDTH-1:0];
    if (shr > PMAX) begin
      sat = 1'b1;
      p   = PMAX[WIDTH-1:0];
    end else if (shr < PMIN) begin
      sat = 1'b1;
      p   = PMIN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/diffeq_solver_fx.sv
// Forward-Euler solver for y'' + 3xy' + 3y = 0 in saturating fixed point.
// One iteration every four cycles (C1..C4), two shared multipliers, abortable.
module diffeq_solver_fx
  import diffeq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] u0,
  input  logic signed [WIDTH-1:0] dx,
  input  logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] u_out,
  output logic [CNT_W-1:0]        iter_count,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    limit_hit
);

  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] SMAX = EW'(sat_max(WIDTH));
  localparam logic signed [EW-1:0] SMIN = EW'(sat_min(WIDTH));

  function automatic logic signed [EW-1:0] ext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] clip(input logic signed [EW-1:0] v);
    if (v > SMAX) return SMAX[WIDTH-1:0];
    if (v < SMIN) return SMIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [EW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] x, y, u, dx_r, a_r;
  logic signed [WIDTH-1:0] p1, t1, xn, p3, p4, p5, yn;
  logic [CNT_W-1:0]        cnt;

  logic signed [WIDTH-1:0] ma_a, ma_b, mb_a, mb_b, ma_p, mb_p;
  logic                    ma_sat, mb_sat;
  logic signed [EW-1:0]    xn_raw, t1_raw, yn_raw, um_raw, un_raw;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    cont_x, cnt_ok;

  // Operand steering: multiplier A serves C1/C2/C3, multiplier B only C2.
  always_comb begin
    ma_a = u;
    ma_b = dx_r;
    mb_a = t1;
    mb_b = y;
    case (state)
      C2:      begin ma_a = t1; ma_b = u; end
      C3:      begin ma_a = p3; ma_b = x; end
      default: ;
    endcase
  end

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_a (
    .a(ma_a), .b(ma_b), .p(ma_p), .sat(ma_sat)
  );

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_b (
    .a(mb_a), .b(mb_b), .p(mb_p), .sat(mb_sat)
  );

  assign xn_raw  = ext(x) + ext(dx_r);
  assign t1_raw  = ext(dx_r) + (ext(dx_r) <<< 1);
  assign yn_raw  = ext(y) + ext(p1);
  assign um_raw  = ext(u) - ext(p5);
  assign un_raw  = ext(clip(um_raw)) - ext(p4);
  assign cnt_nxt = cnt + CNT_W'(1);
  assign cont_x  = xn < a_r;
  assign cnt_ok  = cnt_nxt < CNT_W'(MAX_ITER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (x0 >= a) ? DONE : C1;
      C1:      state_nxt = abort ? IDLE : C2;
      C2:      state_nxt = abort ? IDLE : C3;
      C3:      state_nxt = abort ? IDLE : C4;
      C4:      state_nxt = abort ? IDLE : ((cont_x && cnt_ok) ? C1 : DONE);
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0; y <= '0; u <= '0; dx_r <= '0; a_r <= '0;
      p1 <= '0; t1 <= '0; xn <= '0; p3 <= '0; p4 <= '0; p5 <= '0; yn <= '0;
      cnt <= '0; ovf <= 1'b0; limit_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x <= x0; y <= y0; u <= u0; dx_r <= dx; a_r <= a;
          cnt <= '0; ovf <= 1'b0; limit_hit <= 1'b0;
        end
        C1: if (!abort) begin
          p1 <= ma_p;
          t1 <= clip(t1_raw);
          xn <= clip(xn_raw);
          if (ma_sat || clipped(t1_raw) || clipped(xn_raw)) ovf <= 1'b1;
        end
        C2: if (!abort) begin
          p3 <= ma_p;
          p4 <= mb_p;
          if (ma_sat || mb_sat) ovf <= 1'b1;
        end
        C3: if (!abort) begin
          p5 <= ma_p;
          yn <= clip(yn_raw);
          if (ma_sat || clipped(yn_raw)) ovf <= 1'b1;
        end
        C4: if (!abort) begin
          x   <= xn;
          y   <= yn;
          u   <= clip(un_raw);
          cnt <= cnt_nxt;
          if (clipped(um_raw) || clipped(un_raw)) ovf <= 1'b1;
          // Only a count exit while x is still short of the bound is a limit hit.
          if (cont_x && !cnt_ok) limit_hit <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x_out      = x;
  assign y_out      = y;
  assign u_out      = u;
  assign iter_count = cnt;

endmodule
